mem_stage_ahb: RTL and testbench
================================

// Module: mem_stage_ahb
// PURPOSE
//  Parametrised memory-access pipeline stage: handshaked, single outstanding AHB-Lite transfer with
//  HREADY wait states, byte-lane placement, alignment and bus-error faults. Also resolves branches.
//  Sits between execute and writeback. Supersedes the fixed 64-bit, zero-wait-state memory stage.
// PARAMETERS
//  XLEN    64  register/result width
//  ADDR_W  64  address width
//  DATA_W  64  bus data width; 32 or 64, and DATA_W <= XLEN
//  LANE_B  $clog2(DATA_W/8)  byte-offset bits (derived; not overridden)
// PORTS
//  CLK              in   1       clock; all state updates on posedge
//  RSTN             in   1       synchronous reset, active-low
//  in_valid         in   1       execute-stage op valid
//  in_ready         out  1       stage can accept an op this cycle
//  op_mem           in   1       op is a load/store
//  op_load          in   1       1 = load, 0 = store (when op_mem)
//  funct3           in   3       000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//  address          in   ADDR_W  effective address
//  store_data       in   XLEN    store source value
//  alu_res          in   XLEN    result for non-mem ops; branch compare result
//  rd_i / wb_i      in   5 / 1   destination register / write-back request
//  branch_i         in   1       op is a conditional branch
//  branch_offset_i  in   XLEN    branch target offset
//  pc_i             in   XLEN    op PC
//  flush_i          in   1       squash the op presented this cycle
//  HADDR            out  ADDR_W  bus address
//  HTRANS           out  2       00 IDLE, 10 NONSEQ
//  HWRITE           out  1       bus write
//  HSIZE            out  3       log2 of access bytes
//  HWDATA           out  DATA_W  store data, replicated across lanes
//  HRDATA           in   DATA_W  read data
//  HREADY / HRESP   in   1 / 1   transfer done / error
//  out_valid        out  1       one-cycle pulse: result/fault valid
//  res              out  XLEN    load or pass-through result
//  rd_o / wb_en_o   out  5 / 1   writeback target / enable
//  take_branch      out  1       branch taken
//  branch_offset_o  out  XLEN    registered branch_offset_i
//  pc_o             out  XLEN    registered pc_i
//  fault            out  1       op faulted; qualified by out_valid
//  fault_cause      out  2       01 misaligned, 10 bus error, 11 size > DATA_W
// BEHAVIOUR
//  - Reset (RSTN=0 at posedge): all outputs 0, HTRANS=00, FSM=IDLE; an in-flight transfer is abandoned.
//  - FSM: IDLE -> ADDR -> DATA -> IDLE. in_ready=1 only in IDLE.
//  - Accept = in_valid & in_ready. Squash = accept & (flush_i | take_branch). A squashed op issues no
//    bus transfer, gives out_valid=1, wb_en_o=0, rd_o=0, take_branch=0, fault=0.
//  - Non-mem op: 1-cycle latency; res=alu_res, rd_o=rd_i, wb_en_o=wb_i, out_valid=1.
//  - Branch: take_branch <= branch_i & (alu_res==1), registered with out_valid; else 0.
//  - Mem op, fault check at accept: address low bits nonzero for size -> cause 01; D access with
//    DATA_W=32 -> cause 11. Faulted op: no bus transfer, 1-cycle latency, fault=1, wb_en_o=0.
//  - Mem op, no fault: go to ADDR, driving HTRANS=10, HADDR=address, HWRITE=~op_load,
//    HSIZE=funct3[1:0]. Leave ADDR when HREADY=1; HTRANS=00 in DATA.
//  - DATA: HWDATA holds store_data[size-1:0] replicated DATA_W/size times, stable until HREADY.
//    On HREADY=1: load lane = HRDATA >> (8*address[LANE_B-1:0]), sign- or zero-extended per funct3
//    to XLEN; out_valid=1; return to IDLE. Store: wb_en_o=0. On HRESP=1: fault=1, cause 10, wb_en_o=0.
//  - Total latency with zero wait states: 2 cycles from accept to out_valid; +1 per HREADY=0 cycle.
//  - flush_i during ADDR/DATA has no effect: the transfer and its result complete. Only ops presented
//    while flush_i=1 are squashed.
//  - pc_o and branch_offset_o are captured at accept and held until the next accept.
//  - funct3=111 on a mem op is treated as cause 11.
// TESTING
//  1. ALU op alu_res=0x1234, rd=5, wb=1 -> next cycle out_valid=1, res=0x1234, rd_o=5, wb_en_o=1.
//  2. LB addr 0x1003, HRDATA=0x00000000_80000000, HREADY=1 -> res=0xFFFF_FFFF_FFFF_FF80, 2-cycle latency.
//  3. SH addr 0x2002, data 0xBEEF, HREADY low 3 DATA cycles -> HWDATA=0xBEEF replicated, HSIZE=001,
//     out_valid 5 cycles after accept, in_ready=0 throughout.
//  4. LW addr 0x3002 -> fault=1, cause 01, HTRANS stays 00, wb_en_o=0.
//  5. LD, HRESP=1 in DATA -> fault=1, cause 10, wb_en_o=0; next op accepted the following cycle.
//  6. Branch with alu_res=1 -> take_branch=1; following op squashed (wb_en_o=0, no HTRANS).
//     Then RSTN=0 during ADDR -> HTRANS=00, in_ready=1 after release.

Source files
------------

// File: rtl/mem_stage_ahb.sv
// Memory-access pipeline stage: one outstanding AHB-Lite transfer with wait states, byte-lane
// placement, load extension, alignment/bus faults, plus conditional-branch resolution.
module mem_stage_ahb #(
   parameter int  XLEN   = 64,
   parameter int  ADDR_W = 64,
   parameter int  DATA_W = 64,
   localparam int LANE_B = $clog2(DATA_W / 8)
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              op_mem,
   input  logic              op_load,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] address,
   input  logic [XLEN-1:0]   store_data,
   input  logic [XLEN-1:0]   alu_res,
   input  logic [4:0]        rd_i,
   input  logic              wb_i,
   input  logic              branch_i,
   input  logic [XLEN-1:0]   branch_offset_i,
   input  logic [XLEN-1:0]   pc_i,
   input  logic              flush_i,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic              HRESP,
   output logic              out_valid,
   output logic [XLEN-1:0]   res,
   output logic [4:0]        rd_o,
   output logic              wb_en_o,
   output logic              take_branch,
   output logic [XLEN-1:0]   branch_offset_o,
   output logic [XLEN-1:0]   pc_o,
   output logic              fault,
   output logic [1:0]        fault_cause
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADDR = 2'b01,
      DATA = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [4:0]        rd_q, rd_d;
   logic              wb_en_q, wb_en_d;
   logic              take_branch_q, take_branch_d;
   logic [XLEN-1:0]   boff_q, boff_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              fault_q, fault_d;
   logic [1:0]        cause_q, cause_d;
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic              hwrite_q, hwrite_d;
   logic [2:0]        hsize_q, hsize_d;
   logic [DATA_W-1:0] hwdata_q, hwdata_d;

   // Context of the transfer in flight, consumed when the data phase completes
   logic              ld_q, ld_d;
   logic [2:0]        f3_q, f3_d;
   logic [LANE_B-1:0] lane_q, lane_d;
   logic [4:0]        mrd_q, mrd_d;
   logic              mwb_q, mwb_d;

   logic              accept;
   logic              squash;
   logic              size_bad;
   logic              misaligned;
   logic [2:0]        align_mask;
   logic [DATA_W-1:0] lane_data;

   function automatic logic [DATA_W-1:0] replicate(input logic [XLEN-1:0] sd,
                                                    input logic [1:0]      size);
      logic [DATA_W-1:0] r;
      int                nb;
      r  = '0;
      nb = 1 << size;
      for (int i = 0; i < DATA_W / 8; i++) begin
         r[8*i +: 8] = sd[8*(i % nb) +: 8];
      end
      return r;
   endfunction

   function automatic logic [XLEN-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [2:0]        f3);
      logic [XLEN-1:0] r;
      case (f3)
         3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
         3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
         3'b010:  r = {{(XLEN-32){d[31]}}, d[31:0]};
         3'b100:  r = {{(XLEN-8){1'b0}}, d[7:0]};
         3'b101:  r = {{(XLEN-16){1'b0}}, d[15:0]};
         3'b110:  r = {{(XLEN-32){1'b0}}, d[31:0]};
         default: r = XLEN'(d);
      endcase
      return r;
   endfunction

   assign accept     = in_valid & (state_q == IDLE);
   assign squash     = accept & (flush_i | take_branch_q);
   assign size_bad   = (funct3 == 3'b111) | ((funct3[1:0] == 2'b11) & (DATA_W < 64));
   assign misaligned = |(address[2:0] & align_mask);
   assign lane_data  = HRDATA >> {lane_q, 3'b000};

   always_comb begin
      case (funct3[1:0])
         2'b00:   align_mask = 3'b000;
         2'b01:   align_mask = 3'b001;
         2'b10:   align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      out_valid_d   = 1'b0;
      wb_en_d       = 1'b0;
      take_branch_d = 1'b0;
      fault_d       = 1'b0;
      res_d         = res_q;
      rd_d          = rd_q;
      boff_d        = boff_q;
      pc_d          = pc_q;
      cause_d       = cause_q;
      haddr_d       = haddr_q;
      hwrite_d      = hwrite_q;
      hsize_d       = hsize_q;
      hwdata_d      = hwdata_q;
      ld_d          = ld_q;
      f3_d          = f3_q;
      lane_d        = lane_q;
      mrd_d         = mrd_q;
      mwb_d         = mwb_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               pc_d   = pc_i;
               boff_d = branch_offset_i;
               if (squash) begin
                  out_valid_d = 1'b1;
                  res_d       = '0;
                  rd_d        = '0;
                  cause_d     = 2'b00;
               end else if (!op_mem) begin
                  out_valid_d   = 1'b1;
                  res_d         = alu_res;
                  rd_d          = rd_i;
                  wb_en_d       = wb_i;
                  take_branch_d = branch_i & (alu_res == XLEN'(1));
                  cause_d       = 2'b00;
               end else if (size_bad || misaligned) begin
                  // Size errors win over alignment when both apply
                  out_valid_d = 1'b1;
                  fault_d     = 1'b1;
                  cause_d     = size_bad ? 2'b11 : 2'b01;
                  res_d       = '0;
                  rd_d        = rd_i;
               end else begin
                  state_d  = ADDR;
                  haddr_d  = address;
                  hwrite_d = ~op_load;
                  hsize_d  = {1'b0, funct3[1:0]};
                  hwdata_d = replicate(store_data, funct3[1:0]);
                  ld_d     = op_load;
                  f3_d     = funct3;
                  lane_d   = address[LANE_B-1:0];
                  mrd_d    = rd_i;
                  mwb_d    = wb_i;
               end
            end
         end
         ADDR: begin
            if (HREADY) state_d = DATA;
         end
         DATA: begin
            if (HREADY) begin
               state_d     = IDLE;
               out_valid_d = 1'b1;
               rd_d        = mrd_q;
               if (HRESP) begin
                  fault_d = 1'b1;
                  cause_d = 2'b10;
                  res_d   = '0;
               end else begin
                  cause_d = 2'b00;
                  res_d   = ld_q ? extend(lane_data, f3_q) : '0;
                  wb_en_d = ld_q & mwb_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q       <= IDLE;
         out_valid_q   <= 1'b0;
         res_q         <= '0;
         rd_q          <= '0;
         wb_en_q       <= 1'b0;
         take_branch_q <= 1'b0;
         boff_q        <= '0;
         pc_q          <= '0;
         fault_q       <= 1'b0;
         cause_q       <= 2'b00;
         haddr_q       <= '0;
         hwrite_q      <= 1'b0;
         hsize_q       <= 3'b000;
         hwdata_q      <= '0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         res_q         <= res_d;
         rd_q          <= rd_d;
         wb_en_q       <= wb_en_d;
         take_branch_q <= take_branch_d;
         boff_q        <= boff_d;
         pc_q          <= pc_d;
         fault_q       <= fault_d;
         cause_q       <= cause_d;
         haddr_q       <= haddr_d;
         hwrite_q      <= hwrite_d;
         hsize_q       <= hsize_d;
         hwdata_q      <= hwdata_d;
      end
   end

   always_ff @(posedge CLK) begin
      ld_q   <= ld_d;
      f3_q   <= f3_d;
      lane_q <= lane_d;
      mrd_q  <= mrd_d;
      mwb_q  <= mwb_d;
   end

   assign in_ready        = (state_q == IDLE);
   assign HTRANS          = (state_q == ADDR) ? 2'b10 : 2'b00;
   assign HADDR           = haddr_q;
   assign HWRITE          = hwrite_q;
   assign HSIZE           = hsize_q;
   assign HWDATA          = hwdata_q;
   assign out_valid       = out_valid_q;
   assign res             = res_q;
   assign rd_o            = rd_q;
   assign wb_en_o         = wb_en_q;
   assign take_branch     = take_branch_q;
   assign branch_offset_o = boff_q;
   assign pc_o            = pc_q;
   assign fault           = fault_q;
   assign fault_cause     = cause_q;

endmodule

// File: tb/tb_mem_stage_ahb.sv
// Directed testbench for mem_stage_ahb: ALU pass-through, loads/stores with wait states,
// faults, branch squash, flush and reset during a transfer.
`timescale 1ns/1ps
module tb_mem_stage_ahb;
   localparam int XLEN   = 64;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;

   logic              CLK = 1'b0;
   logic              RSTN;
   logic              in_valid, in_ready, op_mem, op_load, wb_i, branch_i, flush_i;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] address;
   logic [XLEN-1:0]   store_data, alu_res, branch_offset_i, pc_i;
   logic [4:0]        rd_i, rd_o;
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE, HREADY, HRESP;
   logic [2:0]        HSIZE;
   logic [DATA_W-1:0] HWDATA, HRDATA;
   logic              out_valid, wb_en_o, take_branch, fault;
   logic [XLEN-1:0]   res, branch_offset_o, pc_o;
   logic [1:0]        fault_cause;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   mem_stage_ahb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready), .op_mem(op_mem),
      .op_load(op_load), .funct3(funct3), .address(address), .store_data(store_data),
      .alu_res(alu_res), .rd_i(rd_i), .wb_i(wb_i), .branch_i(branch_i),
      .branch_offset_i(branch_offset_i), .pc_i(pc_i), .flush_i(flush_i), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP), .out_valid(out_valid), .res(res), .rd_o(rd_o),
      .wb_en_o(wb_en_o), .take_branch(take_branch), .branch_offset_o(branch_offset_o),
      .pc_o(pc_o), .fault(fault), .fault_cause(fault_cause)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = 0; op_mem = 0; op_load = 0; funct3 = 3'b000; address = '0; store_data = '0;
      alu_res = '0; rd_i = '0; wb_i = 0; branch_i = 0; branch_offset_i = '0; pc_i = '0;
      flush_i = 0; HRDATA = '0; HREADY = 1; HRESP = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      RSTN = 0;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %h want 0", out_valid); end
      checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %h want 0", HTRANS); end
      checks++; if (res !== 64'h0) begin errors++; $display("FAIL rst_res: got %h want 0", res); end
      checks++; if (pc_o !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc_o); end
      checks++; if (HADDR !== 64'h0) begin errors++; $display("FAIL rst_haddr: got %h want 0", HADDR); end
      checks++; if ({wb_en_o, fault, take_branch} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {wb_en_o, fault, take_branch}); end
      RSTN = 1;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %h want 1", in_ready); end
   endtask

   task automatic test_alu();
      clear_inputs();
      in_valid = 1; alu_res = 64'h1234; rd_i = 5; wb_i = 1; pc_i = 64'h100; branch_offset_i = 64'h40;
      tick();
      clear_inputs();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %h want 1", out_valid); end
      checks++; if (res !== 64'h1234) begin errors++; $display("FAIL alu_res: got %h want 1234", res); end
      checks++; if (rd_o !== 5'd5 || wb_en_o !== 1'b1) begin errors++; $display("FAIL alu_wb: got rd %0d wb %b want rd 5 wb 1", rd_o, wb_en_o); end
      checks++; if (pc_o !== 64'h100 || branch_offset_o !== 64'h40) begin errors++; $display("FAIL alu_pc: got %h/%h want 100/40", pc_o, branch_offset_o); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse: got %h want 0", out_valid); end
      checks++; if (pc_o !== 64'h100) begin errors++; $display("FAIL alu_pc_hold: got %h want 100", pc_o); end
   endtask

   task automatic test_load_byte();
      clear_inputs();
      in_valid = 1; op_mem = 1; op_load = 1; funct3 = 3'b000; address = 64'h1003; rd_i = 7; wb_i = 1;
      HRDATA = 64'h0000_0000_8000_0000;
      tick();
      in_valid = 0;
      checks++; if (HTRANS !== 2'b10 || HADDR !== 64'h1003) begin errors++; $display("FAIL lb_addr: got %h %h want 2 1003", HTRANS, HADDR); end
      checks++; if (HWRITE !== 1'b0 || HSIZE !== 3'b000) begin errors++; $display("FAIL lb_ctrl: got %b %b want 0 000", HWRITE, HSIZE); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL lb_busy: got rdy %b vld %b want 0 0", in_ready, out_valid); end
      tick();
      checks++; if (HTRANS !== 2'b00 || out_valid !== 1'b0) begin errors++; $display("FAIL lb_data: got %h %b want 0 0", HTRANS, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lb_valid: got %h want 1", out_valid); end
      checks++; if (res !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_res: got %h want ffffffffffffff80", res); end
      checks++; if (rd_o !== 5'd7 || wb_en_o !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL lb_wb: got %0d %b %b want 7 1 0", rd_o, wb_en_o, fault); end
   endtask

   task automatic test_store_wait();
      clear_inputs();
      in_valid = 1; op_mem = 1; op_load = 0; funct3 = 3'b001; address = 64'h2002;
      store_data = 64'h1111_2222_3333_BEEF; rd_i = 2; wb_i = 1;
      tick();
      in_valid = 0;
      checks++; if (HTRANS !== 2'b10 || HWRITE !== 1'b1 || HSIZE !== 3'b001) begin errors++; $display("FAIL sh_addr: got %h %b %b want 2 1 001", HTRANS, HWRITE, HSIZE); end
      checks++; if (HWDATA !== 64'hBEEF_BEEF_BEEF_BEEF) begin errors++; $display("FAIL sh_hwdata: got %h want beefbeefbeefbeef", HWDATA); end
      tick();
      HREADY = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL sh_wait%0d: got rdy %b vld %b want 0 0", k, in_ready, out_valid); end
         checks++; if (HWDATA !== 64'hBEEF_BEEF_BEEF_BEEF || HTRANS !== 2'b00) begin errors++; $display("FAIL sh_hold%0d: got %h %h want beef.. 0", k, HWDATA, HTRANS); end
      end
      HREADY = 1;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sh_latency5: got %h want 1", out_valid); end
      checks++; if (wb_en_o !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL sh_wb: got %b %b want 0 0", wb_en_o, fault); end
   endtask

   task automatic test_faults();
      clear_inputs();
      in_valid = 1; op_mem = 1; op_load = 1; funct3 = 3'b010; address = 64'h3002; rd_i = 3; wb_i = 1;
      tick();
      clear_inputs();
      checks++; if (out_valid !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'b01) begin errors++; $display("FAIL lw_misalign: got %b %b %b want 1 1 01", out_valid, fault, fault_cause); end
      checks++; if (HTRANS !== 2'b00 || wb_en_o !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL lw_nobus: got %h %b %b want 0 0 1", HTRANS, wb_en_o, in_ready); end
      in_valid = 1; op_mem = 1; op_load = 1; funct3 = 3'b111; address = 64'h5000; wb_i = 1;
      tick();
      clear_inputs();
      checks++; if (fault !== 1'b1 || fault_cause !== 2'b11 || HTRANS !== 2'b00) begin errors++; $display("FAIL f3_111: got %b %b %h want 1 11 0", fault, fault_cause, HTRANS); end
   endtask

   task automatic test_bus_error();
      clear_inputs();
      in_valid = 1; op_mem = 1; op_load = 1; funct3 = 3'b011; address = 64'h4000; rd_i = 6; wb_i = 1;
      tick();
      in_valid = 0;
      checks++; if (HTRANS !== 2'b10 || HSIZE !== 3'b011) begin errors++; $display("FAIL ld_addr: got %h %b want 2 011", HTRANS, HSIZE); end
      tick();
      HRESP = 1;
      tick();
      clear_inputs();
      checks++; if (out_valid !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'b10) begin errors++; $display("FAIL ld_buserr: got %b %b %b want 1 1 10", out_valid, fault, fault_cause); end
      checks++; if (wb_en_o !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ld_err_wb: got %b %b want 0 1", wb_en_o, in_ready); end
      in_valid = 1; alu_res = 64'h55; rd_i = 3; wb_i = 1;
      tick();
      clear_inputs();
      checks++; if (out_valid !== 1'b1 || res !== 64'h55 || fault !== 1'b0) begin errors++; $display("FAIL after_err: got %b %h %b want 1 55 0", out_valid, res, fault); end
   endtask

   task automatic test_flush();
      clear_inputs();
      in_valid = 1; flush_i = 1; alu_res = 64'h99; rd_i = 4; wb_i = 1;
      tick();
      clear_inputs();
      checks++; if (out_valid !== 1'b1 || wb_en_o !== 1'b0 || rd_o !== 5'd0) begin errors++; $display("FAIL flush_squash: got %b %b %0d want 1 0 0", out_valid, wb_en_o, rd_o); end
      in_valid = 1; op_mem = 1; op_load = 1; funct3 = 3'b100; address = 64'h1000; rd_i = 8; wb_i = 1;
      HRDATA = 64'h0000_0000_0000_00F0;
      tick();
      in_valid = 0; flush_i = 1;
      tick();
      flush_i = 0;
      tick();
      checks++; if (out_valid !== 1'b1 || res !== 64'hF0 || wb_en_o !== 1'b1) begin errors++; $display("FAIL flush_inflight: got %b %h %b want 1 f0 1", out_valid, res, wb_en_o); end
   endtask

   task automatic test_branch_reset();
      clear_inputs();
      in_valid = 1; branch_i = 1; alu_res = 64'h0; pc_i = 64'h180;
      tick();
      clear_inputs();
      checks++; if (take_branch !== 1'b0) begin errors++; $display("FAIL br_not_taken: got %b want 0", take_branch); end
      in_valid = 1; branch_i = 1; alu_res = 64'h1; pc_i = 64'h200; branch_offset_i = 64'h80;
      tick();
      clear_inputs();
      checks++; if (take_branch !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL br_taken: got %b %b want 1 1", take_branch, out_valid); end
      checks++; if (pc_o !== 64'h200 || branch_offset_o !== 64'h80) begin errors++; $display("FAIL br_pc: got %h %h want 200 80", pc_o, branch_offset_o); end
      in_valid = 1; op_mem = 1; op_load = 0; funct3 = 3'b010; address = 64'h6000; rd_i = 9; wb_i = 1;
      tick();
      clear_inputs();
      checks++; if (out_valid !== 1'b1 || wb_en_o !== 1'b0 || rd_o !== 5'd0) begin errors++; $display("FAIL br_squash: got %b %b %0d want 1 0 0", out_valid, wb_en_o, rd_o); end
      checks++; if (HTRANS !== 2'b00 || take_branch !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL br_squash_bus: got %h %b %b want 0 0 0", HTRANS, take_branch, fault); end
      in_valid = 1; op_mem = 1; op_load = 1; funct3 = 3'b000; address = 64'h7000;
      tick();
      clear_inputs();
      checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL rst_pre: got %h want 2", HTRANS); end
      RSTN = 0;
      tick();
      checks++; if (HTRANS !== 2'b00 || out_valid !== 1'b0 || HADDR !== 64'h0) begin errors++; $display("FAIL rst_mid: got %h %b %h want 0 0 0", HTRANS, out_valid, HADDR); end
      RSTN = 1;
      tick();
      checks++; if (in_ready !== 1'b1 || HTRANS !== 2'b00 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_after: got %b %h %b want 1 0 0", in_ready, HTRANS, out_valid); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      RSTN = 0;
      clear_inputs();
      test_reset();
      test_alu();
      test_load_byte();
      test_store_wait();
      test_faults();
      test_bus_error();
      test_flush();
      test_branch_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
